// File: rtl/sparse_zeroskip_issue_ctrl.sv
// Zero-skipping issue controller: accepts one cmap per N dense groups and emits
// up to BIT_NONZERO gathered nonzero operands per group through a one-entry output register.
module sparse_zeroskip_issue_ctrl #(
   parameter int BIT_NONZERO   = 8,
   parameter int BIT_GROUPSIZE = 16,
   parameter int DATA_W        = 16,
   parameter int N             = 8
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [BIT_GROUPSIZE-1:0]                       cmap_i,
   input  logic                                           cmap_valid_i,
   output logic                                           cmap_ready_o,
   input  logic [BIT_GROUPSIZE*DATA_W-1:0]                grp_data_i,
   input  logic                                           grp_valid_i,
   output logic                                           grp_ready_o,
   output logic [BIT_GROUPSIZE-1:0]                       idx_cmap_o,
   input  logic [BIT_NONZERO*$clog2(BIT_GROUPSIZE)-1:0]   idx_nz_i,
   output logic [BIT_NONZERO*DATA_W-1:0]                  out_data_o,
   output logic [BIT_NONZERO-1:0]                         out_lane_en_o,
   output logic                                           out_last_o,
   output logic                                           out_valid_o,
   input  logic                                           out_ready_i,
   output logic                                           err_o
);

   localparam int IDX_W = $clog2(BIT_GROUPSIZE);
   localparam int NZ_W  = $clog2(BIT_NONZERO + 1);
   localparam int PC_W  = $clog2(BIT_GROUPSIZE + 1);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]                    state;
   logic [CNT_W-1:0]              grp_cnt;
   logic [NZ_W-1:0]               nz_cnt;
   logic [PC_W-1:0]               cmap_pop;
   logic [NZ_W-1:0]               nz_next;
   logic                          cmap_over;
   logic                          cmap_fire;
   logic                          grp_fire;
   logic                          grp_last;
   logic [BIT_NONZERO*DATA_W-1:0] gather_data;
   logic [BIT_NONZERO-1:0]        gather_en;

   // Handshakes: a transfer happens on a rising edge where valid && ready; a
   // producer holds valid and its payload stable until that edge.
   assign cmap_ready_o = (state == IDLE);
   assign grp_ready_o  = (state == RUN) && (!out_valid_o || out_ready_i);
   assign cmap_fire    = cmap_ready_o && cmap_valid_i;
   assign grp_fire     = grp_ready_o && grp_valid_i;
   assign grp_last     = (grp_cnt == CNT_W'(N - 1));

   always_comb begin
      cmap_pop = '0;
      for (int k = 0; k < BIT_GROUPSIZE; k++) begin
         cmap_pop = cmap_pop + PC_W'(cmap_i[k]);
      end
   end

   assign cmap_over = (cmap_pop > PC_W'(BIT_NONZERO));
   assign nz_next   = cmap_over ? NZ_W'(BIT_NONZERO) : NZ_W'(cmap_pop);

   // Lanes at or above nz_cnt are forced to zero whatever the index unit returns there.
   always_comb begin
      logic [IDX_W-1:0] lane_idx;
      gather_data = '0;
      gather_en   = '0;
      lane_idx    = '0;
      for (int j = 0; j < BIT_NONZERO; j++) begin
         lane_idx = idx_nz_i[j*IDX_W +: IDX_W];
         if (j < int'(nz_cnt)) begin
            gather_en[j] = 1'b1;
            gather_data[j*DATA_W +: DATA_W] = grp_data_i[lane_idx*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grp_cnt    <= '0;
         nz_cnt     <= '0;
         idx_cmap_o <= '0;
         err_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmap_fire) begin
                  idx_cmap_o <= cmap_i;
                  nz_cnt     <= nz_next;
                  grp_cnt    <= '0;
                  state      <= RUN;
                  if (cmap_over) begin
                     err_o <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (grp_fire) begin
                  if (grp_last) begin
                     grp_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     grp_cnt <= grp_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output slice: reload on group accept, otherwise drain on out_ready_i.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_o    <= '0;
         out_lane_en_o <= '0;
         out_last_o    <= 1'b0;
         out_valid_o   <= 1'b0;
      end else if (grp_fire) begin
         out_data_o    <= gather_data;
         out_lane_en_o <= gather_en;
         out_last_o    <= grp_last;
         out_valid_o   <= 1'b1;
      end else if (out_ready_i) begin
         out_valid_o   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sparse_zeroskip_issue_ctrl.sv
// Bench for sparse_zeroskip_issue_ctrl: random stimulus, an index-unit model and
// a transaction scoreboard built from the cmap/gather rules.
module tb_sparse_zeroskip_issue_ctrl;

   localparam int NZ = 8;
   localparam int GS = 16;
   localparam int DW = 16;
   localparam int NG = 8;
   localparam int IW = 4;
   localparam int W  = NZ*DW + NZ + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [GS-1:0]      cmap_i = '0;
   logic               cmap_valid_i = 1'b0;
   logic               cmap_ready_o;
   logic [GS*DW-1:0]   grp_data_i = '0;
   logic               grp_valid_i = 1'b0;
   logic               grp_ready_o;
   logic [GS-1:0]      idx_cmap_o;
   logic [NZ*IW-1:0]   idx_nz;
   logic [NZ*DW-1:0]   out_data_o;
   logic [NZ-1:0]      out_lane_en_o;
   logic               out_last_o;
   logic               out_valid_o;
   logic               out_ready_i = 1'b0;
   logic               err_o;

   int checks = 0;
   int errors = 0;

   sparse_zeroskip_issue_ctrl #(
      .BIT_NONZERO(NZ), .BIT_GROUPSIZE(GS), .DATA_W(DW), .N(NG)
   ) dut (
      .clk(clk), .rst(rst),
      .cmap_i(cmap_i), .cmap_valid_i(cmap_valid_i), .cmap_ready_o(cmap_ready_o),
      .grp_data_i(grp_data_i), .grp_valid_i(grp_valid_i), .grp_ready_o(grp_ready_o),
      .idx_cmap_o(idx_cmap_o), .idx_nz_i(idx_nz),
      .out_data_o(out_data_o), .out_lane_en_o(out_lane_en_o), .out_last_o(out_last_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // External index unit: positions of set bits in ascending order; unused lanes carry junk.
   always_comb begin : idx_unit
      int n;
      idx_nz = {NZ{4'd3}};
      n = 0;
      for (int k = 0; k < GS; k++) begin
         if (idx_cmap_o[k] && n < NZ) begin
            idx_nz[n*IW +: IW] = 4'(k);
            n++;
         end
      end
   end

   function automatic logic [W-1:0] make_exp(input logic [GS-1:0] cm,
                                             input logic [GS*DW-1:0] d, input bit last);
      logic [NZ*DW-1:0] dat;
      logic [NZ-1:0]    en;
      int               nz;
      dat = '0;
      en  = '0;
      nz  = 0;
      for (int k = 0; k < GS; k++) begin
         if (cm[k] && nz < NZ) begin
            dat[nz*DW +: DW] = d[k*DW +: DW];
            en[nz] = 1'b1;
            nz++;
         end
      end
      return {dat, en, last};
   endfunction

   function automatic logic [GS*DW-1:0] rand_data();
      logic [GS*DW-1:0] d;
      for (int k = 0; k < GS*DW/32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   // Scoreboard and reference model, evaluated mid-cycle with inputs stable.
   logic [W-1:0]  exp_q[$];
   bit            m_run = 1'b0;
   logic [GS-1:0] m_cmap = '0;
   bit            m_err = 1'b0;
   int            m_grp = 0;
   int            cyc = 0;
   int            cmap_acc_cnt = 0, grp_acc_cnt = 0, out_acc_cnt = 0, last_cnt = 0;
   int            last_grp_cyc = 0, last_cmap_cyc = 0;

   always @(negedge clk) begin
      bit exp_ready, cf, gf, of;
      cyc++;
      if (rst) begin
         m_run = 1'b0; m_cmap = '0; m_err = 1'b0; m_grp = 0;
         exp_q.delete();
      end else begin
         exp_ready = m_run && (exp_q.size() == 0 || out_ready_i);
         checks++;
         if (cmap_ready_o !== !m_run) begin
            errors++; $display("FAIL cmap_ready: got %b expected %b cyc %0d", cmap_ready_o, !m_run, cyc);
         end
         checks++;
         if (grp_ready_o !== exp_ready) begin
            errors++; $display("FAIL grp_ready: got %b expected %b cyc %0d", grp_ready_o, exp_ready, cyc);
         end
         checks++;
         if (out_valid_o !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL out_valid: got %b expected %b cyc %0d", out_valid_o, exp_q.size() != 0, cyc);
         end
         if (exp_q.size() != 0) begin
            checks++;
            if ({out_data_o, out_lane_en_o, out_last_o} !== exp_q[0]) begin
               errors++;
               $display("FAIL out_word: got %h expected %h cyc %0d", {out_data_o, out_lane_en_o, out_last_o}, exp_q[0], cyc);
            end
         end
         checks++;
         if (err_o !== m_err) begin
            errors++; $display("FAIL err: got %b expected %b cyc %0d", err_o, m_err, cyc);
         end
         checks++;
         if (idx_cmap_o !== m_cmap) begin
            errors++; $display("FAIL idx_cmap: got %h expected %h cyc %0d", idx_cmap_o, m_cmap, cyc);
         end
         cf = !m_run && cmap_valid_i;
         gf = m_run && grp_valid_i && exp_ready;
         of = (exp_q.size() != 0) && out_ready_i;
         if (of) begin
            if (exp_q[0][0]) last_cnt++;
            void'(exp_q.pop_front());
            out_acc_cnt++;
         end
         if (gf) begin
            exp_q.push_back(make_exp(m_cmap, grp_data_i, m_grp == NG-1));
            grp_acc_cnt++;
            if (m_grp == NG-1) begin
               m_run = 1'b0; m_grp = 0; last_grp_cyc = cyc;
            end else begin
               m_grp++;
            end
         end
         if (cf) begin
            m_run = 1'b1; m_cmap = cmap_i; m_grp = 0;
            if ($countones(cmap_i) > NZ) m_err = 1'b1;
            cmap_acc_cnt++; last_cmap_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_cmap(input logic [GS-1:0] c);
      int n0;
      n0 = cmap_acc_cnt;
      cmap_i = c;
      cmap_valid_i = 1'b1;
      for (int t = 0; t < 50 && cmap_acc_cnt == n0; t++) tick();
      cmap_valid_i = 1'b0;
      checks++;
      if (cmap_acc_cnt == n0) begin
         errors++; $display("FAIL cmap_timeout: got 0 accepts expected 1");
      end
   endtask

   task automatic run_groups(input int n, input int pv, input int pr);
      int target;
      target = grp_acc_cnt + n;
      for (int t = 0; t < 2000 && grp_acc_cnt < target; t++) begin
         grp_valid_i = ($urandom_range(99) < pv);
         grp_data_i  = rand_data();
         out_ready_i = ($urandom_range(99) < pr);
         tick();
      end
      checks++;
      if (grp_acc_cnt < target) begin
         errors++; $display("FAIL group_timeout: got %0d expected %0d", grp_acc_cnt, target);
      end
      grp_valid_i = 1'b0;
      out_ready_i = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({out_valid_o, out_lane_en_o, out_data_o, out_last_o, err_o, idx_cmap_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got nonzero expected 0");
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({cmap_ready_o, grp_ready_o} !== 2'b10) begin
         errors++; $display("FAIL reset_ready: got %b expected 10", {cmap_ready_o, grp_ready_o});
      end
   endtask

   task automatic test_idle_ignores_groups();
      int g0;
      g0 = grp_acc_cnt;
      grp_valid_i = 1'b1;
      out_ready_i = 1'b1;
      for (int t = 0; t < 3; t++) begin
         grp_data_i = rand_data();
         tick();
      end
      grp_valid_i = 1'b0;
      checks++;
      if (grp_acc_cnt != g0 || out_valid_o !== 1'b0) begin
         errors++; $display("FAIL idle_group: got %0d accepts expected 0", grp_acc_cnt - g0);
      end
   endtask

   task automatic test_pattern_8421();
      int c0, g0, l0;
      send_cmap(16'h8421);
      c0 = out_acc_cnt; g0 = grp_acc_cnt; l0 = last_cnt;
      out_ready_i = 1'b1;
      grp_valid_i = 1'b1;
      for (int i = 1; i <= NG; i++) begin
         grp_data_i = rand_data();
         tick();
         checks++;
         if (out_acc_cnt - c0 != i - 1) begin
            errors++; $display("FAIL stream_latency: got %0d outputs expected %0d", out_acc_cnt - c0, i - 1);
         end
         if (i == 1) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_lane_en_o !== 8'h0F) begin
               errors++; $display("FAIL lane_en_8421: got %b/%h expected 1/0f", out_valid_o, out_lane_en_o);
            end
         end
      end
      grp_valid_i = 1'b0;
      tick();
      checks++;
      if (out_acc_cnt - c0 != NG || grp_acc_cnt - g0 != NG || last_cnt - l0 != 1 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL totals_8421: got out %0d grp %0d last %0d expected %0d %0d 1",
                  out_acc_cnt - c0, grp_acc_cnt - g0, last_cnt - l0, NG, NG);
      end
   endtask

   task automatic test_zero_cmap();
      int c0;
      send_cmap(16'h0000);
      c0 = out_acc_cnt;
      out_ready_i = 1'b1;
      grp_valid_i = 1'b1;
      for (int i = 0; i < NG; i++) begin
         grp_data_i = rand_data();
         tick();
         if (out_valid_o) begin
            checks++;
            if (out_lane_en_o !== '0 || out_data_o !== '0) begin
               errors++; $display("FAIL zero_lanes: got %h/%h expected 0/0", out_lane_en_o, out_data_o);
            end
         end
      end
      grp_valid_i = 1'b0;
      tick();
      checks++;
      if (out_acc_cnt - c0 != NG) begin
         errors++; $display("FAIL zero_count: got %0d expected %0d", out_acc_cnt - c0, NG);
      end
   endtask

   task automatic test_stall();
      int g0, c0;
      logic [W:0] snap;
      send_cmap(16'($urandom));
      g0 = grp_acc_cnt; c0 = out_acc_cnt;
      out_ready_i = 1'b1;
      grp_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         grp_data_i = rand_data();
         tick();
      end
      out_ready_i = 1'b0;
      #1;
      snap = {out_valid_o, out_data_o, out_lane_en_o, out_last_o};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (grp_ready_o !== 1'b0) begin
            errors++; $display("FAIL stall_grp_ready: got %b expected 0", grp_ready_o);
         end
         grp_data_i = rand_data();
         tick();
         checks++;
         if ({out_valid_o, out_data_o, out_lane_en_o, out_last_o} !== snap) begin
            errors++; $display("FAIL stall_stable: got %h expected %h", {out_valid_o, out_data_o, out_lane_en_o, out_last_o}, snap);
         end
      end
      run_groups(NG - (grp_acc_cnt - g0), 100, 100);
      checks++;
      if (grp_acc_cnt - g0 != NG || out_acc_cnt - c0 != NG) begin
         errors++; $display("FAIL stall_count: got %0d/%0d expected %0d", grp_acc_cnt - g0, out_acc_cnt - c0, NG);
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = cmap_acc_cnt;
      cmap_i = 16'($urandom);
      cmap_valid_i = 1'b1;
      grp_valid_i = 1'b1;
      out_ready_i = 1'b1;
      for (int t = 0; t < 100 && cmap_acc_cnt < n0 + 2; t++) begin
         grp_data_i = rand_data();
         tick();
      end
      cmap_valid_i = 1'b0;
      grp_valid_i = 1'b0;
      checks++;
      if (cmap_acc_cnt != n0 + 2 || last_cmap_cyc - last_grp_cyc != 1) begin
         errors++;
         $display("FAIL cmap_gap: got %0d cycles (%0d cmaps) expected 1", last_cmap_cyc - last_grp_cyc, cmap_acc_cnt - n0);
      end
      run_groups(NG, 100, 100);
   endtask

   task automatic test_overflow_cmap();
      logic [GS*DW-1:0] d;
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL err_before: got %b expected 0", err_o);
      end
      send_cmap(16'hFFFF);
      checks++;
      if (err_o !== 1'b1) begin
         errors++; $display("FAIL err_after: got %b expected 1", err_o);
      end
      d = rand_data();
      grp_data_i = d;
      grp_valid_i = 1'b1;
      out_ready_i = 1'b1;
      tick();
      grp_valid_i = 1'b0;
      checks++;
      if (out_lane_en_o !== 8'hFF || out_data_o !== d[NZ*DW-1:0]) begin
         errors++; $display("FAIL full_lanes: got %h/%h expected ff/%h", out_lane_en_o, out_data_o, d[NZ*DW-1:0]);
      end
      run_groups(NG - 1, 80, 80);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         if (r % 3 == 2) send_cmap(16'($urandom));
         else send_cmap(16'($urandom & $urandom));
         run_groups(NG, 70, 60);
      end
   endtask

   task automatic test_reset_mid_run();
      int g0, l0;
      send_cmap(16'h00F3);
      out_ready_i = 1'b1;
      grp_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         grp_data_i = rand_data();
         tick();
      end
      grp_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid_o, out_lane_en_o, out_data_o, out_last_o, err_o, idx_cmap_o} !== '0) begin
         errors++; $display("FAIL midrun_reset_out: got nonzero expected 0");
      end
      checks++;
      if ({cmap_ready_o, grp_ready_o} !== 2'b10) begin
         errors++; $display("FAIL midrun_reset_ready: got %b expected 10", {cmap_ready_o, grp_ready_o});
      end
      tick();
      tick();
      rst = 1'b0;
      g0 = grp_acc_cnt;
      grp_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      grp_valid_i = 1'b0;
      checks++;
      if (grp_acc_cnt != g0) begin
         errors++; $display("FAIL post_reset_group: got %0d accepts expected 0", grp_acc_cnt - g0);
      end
      l0 = last_cnt;
      send_cmap(16'h8421);
      run_groups(NG, 100, 100);
      checks++;
      if (grp_acc_cnt - g0 != NG || last_cnt - l0 != 1) begin
         errors++; $display("FAIL post_reset_run: got %0d groups %0d last expected %0d 1", grp_acc_cnt - g0, last_cnt - l0, NG);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_ignores_groups();
      test_pattern_8421();
      test_zero_cmap();
      test_stall();
      test_back_to_back();
      test_random();
      test_overflow_cmap();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sparse_zeroskip_issue_ctrl.md
SPARSE_ZEROSKIP_ISSUE_CTRL -- requirements
Module: sparse_zeroskip_issue_ctrl

Interface
REQ-001 SHALL have parameter BIT_NONZERO, default 8: maximum nonzeros per group, which is also the number of output lanes.
REQ-002 SHALL have parameter BIT_GROUPSIZE, default 16: number of dense elements per group (cmap width).
REQ-003 SHALL have parameter DATA_W, default 16: element width (FP16).
REQ-004 SHALL have parameter N, default 8: number of groups that share one cmap.
REQ-005 SHALL have ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cmap_i  in  BIT_GROUPSIZE  compressed bitmap for the next N groups.
- cmap_valid_i  in  1  cmap offer.
- cmap_ready_o  out  1  cmap accept.
- grp_data_i  in  BIT_GROUPSIZE*DATA_W  dense group; element k at bits [k*DATA_W +: DATA_W].
- grp_valid_i  in  1  group offer.
- grp_ready_o  out  1  group accept.
- idx_cmap_o  out  BIT_GROUPSIZE  registered cmap driven to the external index unit.
- idx_nz_i  in  BIT_NONZERO*clog2(BIT_GROUPSIZE)  combinational nz_index returned by the index unit.
- out_data_o  out  BIT_NONZERO*DATA_W  gathered nonzero operands.
- out_lane_en_o  out  BIT_NONZERO  per-lane valid mask.
- out_last_o  out  1  marks group N-1 of the current cmap.
- out_valid_o  out  1  output offer.
- out_ready_i  in  1  output accept.
- err_o  out  1  sticky flag: cmap popcount > BIT_NONZERO.

Function
REQ-006 SHALL implement FSM states IDLE and RUN.
REQ-007 IDLE: cmap_ready_o=1 and grp_ready_o=0; on cmap_valid_i, SHALL register cmap_i into idx_cmap_o, register nz_cnt = min(popcount(cmap_i), BIT_NONZERO), clear grp_cnt to 0, and go to RUN.
REQ-008 RUN: cmap_ready_o=0; grp_ready_o = !out_valid_o || out_ready_i (registered-slice flow-through).
REQ-009 On a group handshake, SHALL load the output register on the next edge with 1-cycle latency:
- lane j data = grp_data_i element idx_nz_i[j] when j < nz_cnt, else 0.
- out_lane_en_o = (1<<nz_cnt)-1.
- out_last_o = (grp_cnt==N-1).
- out_valid_o = 1.
REQ-010 grp_cnt SHALL increment per accepted group; on accept with grp_cnt==N-1, SHALL return to IDLE and clear grp_cnt.
REQ-011 A new cmap SHALL NOT be accepted in the cycle of the last group accept (one IDLE cycle minimum between cmaps).
REQ-012 out_valid_o SHALL hold, and out_* SHALL remain stable, while out_valid_o && !out_ready_i.
REQ-013 out_valid_o SHALL clear on out_ready_i when no new group is accepted in the same cycle.
REQ-014 Simultaneous out handshake and group accept SHALL reload the output register with no bubble, sustaining 1 group/cycle.
REQ-015 Zero cmap: nz_cnt=0, out_lane_en_o=0, all lanes 0; all N groups SHALL still be consumed and emitted.
REQ-016 popcount(cmap_i) > BIT_NONZERO at acceptance SHALL set err_o (sticky until reset); nz_cnt SHALL saturate at BIT_NONZERO; processing SHALL continue.
REQ-017 idx_cmap_o SHALL remain constant for the whole RUN period; idx_nz_i SHALL be sampled only during RUN.
REQ-018 grp_valid_i in IDLE SHALL be ignored (not consumed); cmap_valid_i in RUN SHALL be ignored.

Reset
REQ-019 rst asserted SHALL asynchronously force:
- state=IDLE, grp_cnt=0, nz_cnt=0.
- idx_cmap_o=0, out_data_o=0, out_lane_en_o=0.
- out_last_o=0, out_valid_o=0, err_o=0.
REQ-020 rst mid-RUN SHALL discard the partial cmap and any pending output; after rst deassert, the first accepted transaction SHALL be a cmap.

Verification
REQ-021 cmap=16'h8421, N=8, out_ready_i=1, 8 back-to-back groups:
- 8 outputs on consecutive cycles, first output one cycle after first group accept.
- out_lane_en_o=8'h0F; lanes 0-3 = elements 0,5,10,15.
- out_last_o only on the 8th output.
REQ-022 cmap=16'hFFFF -> err_o=1 from the cycle after acceptance; out_lane_en_o=8'hFF; lanes = elements 0..7.
REQ-023 cmap=16'h0000 -> 8 outputs, each with out_lane_en_o=0 and out_data_o=0.
REQ-024 out_ready_i low for 5 cycles mid-stream:
- out_* stable throughout the stall.
- grp_ready_o=0 while output is full.
- no group lost or duplicated (scoreboard on element values).
REQ-025 cmap_valid_i held high continuously -> next cmap accepted exactly one cycle after the last group accept, never earlier.
REQ-026 rst asserted after group 3 of 8 -> all outputs 0 immediately; next accepted handshake is a cmap; grp_cnt restarts at 0.
